// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one WIDTH-bit adder between NUM_REQ requesters
//   clk, reset (async, active-high)
//   req_valid/req_ready       per-requester request and one-hot accept pulse
//   req_in0/req_in1           packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid/resp_ready     response handshake carrying resp_id, resp_sum, resp_carry
//   busy                      high whenever an operation is in flight
//   Define ADDER_ARBITER_CARRY_EN to build and register the adder carry-out.
module adder_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_in0,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
    output logic                     resp_carry,
    output logic                     busy
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_id;
    logic [ID_W-1:0] idx;
    logic            gnt_any;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_sum;
    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end
    assign req_ready = (state == IDLE && gnt_any && !reset) ? NUM_REQ'(1) << gnt_id : '0;
    assign busy      = state != IDLE;
`ifdef ADDER_ARBITER_CARRY_EN
    logic add_carry;
    assign {add_carry, add_sum} = {1'b0, op_a} + {1'b0, op_b};
`else
    assign add_sum    = op_a + op_b;
    assign resp_carry = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            resp_id    <= '0;
            resp_sum   <= '0;
            resp_valid <= 1'b0;
`ifdef ADDER_ARBITER_CARRY_EN
            resp_carry <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (gnt_any) begin
                    op_a    <= req_in0[gnt_id*WIDTH +: WIDTH];
                    op_b    <= req_in1[gnt_id*WIDTH +: WIDTH];
                    resp_id <= gnt_id;
                    state   <= EXEC;
                end
                EXEC: begin
                    resp_sum   <= add_sum;
`ifdef ADDER_ARBITER_CARRY_EN
                    resp_carry <= add_carry;
`endif
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: if (resp_ready) begin
                    // Pointer advances past the owner only once its response completes.
                    resp_valid <= 1'b0;
                    rr_ptr     <= ID_W'((int'(resp_id) + 1) % NUM_REQ);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter with directed and random stimulus
module tb_adder_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    typedef struct {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        carry;
    } exp_t;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [N*W-1:0] req_in0;
    logic [N*W-1:0] req_in1;
    logic [N-1:0]  req_ready;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_id;
    logic [W-1:0]  resp_sum;
    logic          resp_carry;
    logic          busy;
    logic [W-1:0]  a [N];
    logic [W-1:0]  b [N];
    exp_t          q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            m_ptr = 0;
    bit            m_busy = 0;
    int            m_gcyc = 0;
    logic [1:0]    m_id = '0;
    bit            hold = 0;
    logic [1:0]    h_id;
    logic [15:0]   h_sum;
    always #5 clk = ~clk;
    assign req_in0 = {a[3], a[2], a[1], a[0]};
    assign req_in1 = {b[3], b[2], b[1], b[0]};
    adder_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_in0(req_in0), .req_in1(req_in1),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_sum(resp_sum), .resp_carry(resp_carry), .busy(busy)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    // Reference model: arbitration rule and timing expectations per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [16:0] full;
        int g;
        cyc++;
        if (reset) begin
            chk("rst_req_ready", 32'(req_ready), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_resp_sum", 32'(resp_sum), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            m_ptr = 0;
            m_busy = 0;
            q.delete();
        end else if (!m_busy) begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            chk("idle_busy", 32'(busy), 0);
            chk("idle_resp_valid", 32'(resp_valid), 0);
            chk("grant", 32'(req_ready), g < 0 ? 0 : 32'(1) << g);
            if (g >= 0) begin
                full = {1'b0, a[g]} + {1'b0, b[g]};
                e.id = 2'(g);
                e.sum = full[15:0];
`ifdef ADDER_ARBITER_CARRY_EN
                e.carry = full[16];
`else
                e.carry = 1'b0;
`endif
                q.push_back(e);
                m_busy = 1;
                m_gcyc = cyc;
                m_id = 2'(g);
            end
        end else begin
            chk("busy", 32'(busy), 1);
            chk("no_grant_while_busy", 32'(req_ready), 0);
            chk("resp_valid_timing", 32'(resp_valid), 32'(cyc >= m_gcyc + 2));
            if (resp_valid && resp_ready) begin
                m_busy = 0;
                m_ptr = (int'(m_id) + 1) % N;
            end
        end
    end
    // Monitor: pops the scoreboard on each response handshake and checks stall stability.
    always @(negedge clk) begin
        exp_t e;
        if (reset) hold = 0;
        else begin
            if (hold) begin
                chk("stall_valid", 32'(resp_valid), 1);
                chk("stall_id", 32'(resp_id), 32'(h_id));
                chk("stall_sum", 32'(resp_sum), 32'(h_sum));
            end
            hold = resp_valid && !resp_ready;
            h_id = resp_id;
            h_sum = resp_sum;
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) chk("unexpected_resp", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_sum", 32'(resp_sum), 32'(e.sum));
                    chk("resp_carry", 32'(resp_carry), 32'(e.carry));
                end
            end
        end
    end
    task automatic step(input logic [N-1:0] v, input logic rr, input logic rs);
        @(posedge clk);
        #1;
        req_valid = v;
        resp_ready = rr;
        reset = rs;
    endtask
    initial begin
        for (int i = 0; i < N; i++) begin
            a[i] = 16'(i * 1000 + 7);
            b[i] = 16'(i * 333 + 1);
        end
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 0);
        // Single request with known sum 2649.
        a[0] = 16'd2536;
        b[0] = 16'd113;
        step(4'b0001, 1, 0);
        for (int i = 0; i < 4; i++) step(4'b0000, 1, 0);
        // All requesters from reset: rotation 0,1,2,3,0.
        step(4'b0000, 1, 1);
        step(4'b1111, 1, 0);
        for (int i = 0; i < 15; i++) step(4'b1111, 1, 0);
        step(4'b0000, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        // Backpressure with a competing requester waiting.
        step(4'b0000, 1, 1);
        step(4'b0001, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        step(4'b0010, 0, 0);
        for (int i = 0; i < 7; i++) step(4'b0100, 0, 0);
        for (int i = 0; i < 6; i++) step(4'b0000, 1, 0);
        // Carry/wrap boundary.
        a[2] = 16'hFFFF;
        b[2] = 16'h0001;
        a[3] = 16'hFFFF;
        b[3] = 16'hFFFF;
        step(4'b0100, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        step(4'b1000, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        // Reset while in EXEC, then all valid must grant requester 0.
        step(4'b0010, 1, 0);
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 1);
        step(4'b0000, 1, 0);
        step(4'b1111, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        // rr_ptr now 1; only req3 valid wraps past 1,2; then 0 follows.
        step(4'b1000, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        step(4'b1111, 1, 0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1, 0);
        // Random traffic with backpressure and occasional resets.
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < N; j++) begin
                a[j] = 16'($urandom);
                b[j] = 16'($urandom);
            end
            step(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 80) == 0);
        end
        for (int i = 0; i < 6; i++) step(4'b0000, 1, 0);
        chk("drain", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
